decrypt_key_sequencer: RTL and testbench
========================================

// Module: decrypt_key_sequencer
// PURPOSE
//  Controller between the decryption key schedule and the decryption round datapath.
//  The schedule emits round-key triples in forward order, but decryption consumes them in reverse.
//  This block enables the schedule and buffers all NUM_ROUNDS triples.
//  It then replays them last-to-first to the round datapath over a valid/ack handshake.
//  It also reports busy and done status to the top-level crypto controller.
// PARAMETERS
//  NUM_ROUNDS  32                     number of key triples per operation (3 keys/round, 96 keys)
//  KW          8                      width of one round key
//  IDXW        $clog2(NUM_ROUNDS)     width of round index / buffer pointers
// PORTS
//  CLK        in   1     system clock, rising edge
//  RST_N      in   1     asynchronous active-low reset
//  start      in   1     request one decryption pass; sampled in IDLE only
//  abort      in   1     synchronous abort; highest priority after reset
//  key_new    in   1     key changed since last pass; used only with KEY_CACHE_EN
//  ks_en      out  1     enable to key schedule; high exactly while in FILL
//  ks_vld     in   1     key schedule presents a valid triple this cycle
//  ks_k0      in   KW    key schedule triple, key 0
//  ks_k1      in   KW    key schedule triple, key 1
//  ks_k2      in   KW    key schedule triple, key 2
//  rnd_vld    out  1     round keys valid to datapath
//  rnd_ack    in   1     datapath accepts the current triple
//  rnd_k0     out  KW    round key 0 for the current round
//  rnd_k1     out  KW    round key 1 for the current round
//  rnd_k2     out  KW    round key 2 for the current round
//  rnd_idx    out  IDXW  buffer index of the current triple (NUM_ROUNDS-1 down to 0)
//  busy       out  1     pass in progress
//  done       out  1     single-cycle pulse on pass completion
// BEHAVIOUR
//  Reset: all outputs are 0, state IDLE, wptr/rptr 0, cache_vld 0. Buffer contents are don't-care.
//  FSM states: IDLE -> FILL -> RUN -> DONE -> IDLE.
//  IDLE: start=1 -> FILL, wptr=0. busy rises in the next cycle.
//  FILL: ks_en=1. On ks_vld=1, write {k0,k1,k2} at wptr and increment wptr.
//   ks_vld=0 stalls FILL without limit.
//   Write at wptr==NUM_ROUNDS-1 -> RUN with rptr=NUM_ROUNDS-1. ks_en drops in the same transition.
//  RUN: rnd_vld=1; rnd_k*/rnd_idx come from buf[rptr].
//   A transfer occurs when rnd_vld && rnd_ack.
//   Outputs hold stable while rnd_ack=0.
//   Transfer with rptr>0 -> rptr-1. Transfer with rptr==0 -> DONE, and rnd_vld drops next cycle.
//   rnd_ack while rnd_vld=0 is ignored.
//  DONE: done=1 for one cycle, busy=1 in that cycle. Then IDLE, busy=0.
//  start while busy is ignored; it is not queued. ks_vld outside FILL is ignored.
//  abort=1 in any non-IDLE state:
//   next state IDLE; ks_en, rnd_vld and busy drop next cycle; no done pulse; cache_vld cleared.
//  Simultaneous start+abort in IDLE: abort wins and the block stays in IDLE.
//  RST_N low mid-pass forces the reset state immediately (asynchronous).
//  Latency with ks_vld held high: start at cycle 0, FILL cycles 1..N, first rnd_vld at cycle N+1.
//  Pointers never wrap: wptr saturates at NUM_ROUNDS-1 and rptr stops at 0.
// CONFIGURATION
//  KEY_CACHE_EN defined:
//   A completed pass sets cache_vld.
//   In IDLE, start with cache_vld=1 and key_new=0 skips FILL and goes straight to RUN with rptr=NUM_ROUNDS-1.
//   start with key_new=1 clears cache_vld and does a normal FILL.
//  KEY_CACHE_EN undefined:
//   key_new is unused and there is no cache_vld register.
//   Every start performs FILL.
// STRUCTURE
//  Package crypt_pkg holds shared definitions:
//   KW and NUM_ROUNDS defaults;
//   the state enum {IDLE, FILL, RUN, DONE};
//   the key-triple type (3*KW bits).
//  Sub-module key_triple_buf: NUM_ROUNDS x 3*KW register file.
//   One synchronous write port, one combinational read port, no reset on storage.
//  FSM, pointers and cache flag stay in this module.
// TESTING
//  1. Reset, then start with ks_vld=1 throughout (N=32):
//     ks_en high on cycles 1-32; rnd_vld at cycle 33 with rnd_idx=31.
//     With rnd_ack=1, idx counts 31..0, keys equal the triples written at the same index,
//     and done pulses one cycle after the idx-0 transfer.
//  2. ks_vld toggled 1/0 during FILL: exactly 32 writes; RUN starts after the 32nd valid; no extra writes.
//  3. rnd_ack=0 for 5 cycles at rnd_idx=20: rnd_k*/rnd_idx held constant; then resumes at 19.
//  4. start pulsed during RUN: no effect and exactly one done pulse.
//     abort at FILL write 10: IDLE next cycle, ks_en=0, no done.
//  5. RST_N low for 1 cycle at rnd_idx=5: all outputs 0 immediately; a new start refills from wptr=0.
//  6. KEY_CACHE_EN builds:
//     second start with key_new=0 gives rnd_vld at cycle 1, rnd_idx=31, no ks_en;
//     start with key_new=1 performs FILL.
//     Non-KEY_CACHE_EN builds: the second start always fills.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared definitions for the decryption key sequencer: default sizes,
// the sequencer state encoding and the packed key-triple type.
package crypt_pkg;

  // Default width of one round key and number of key triples per pass.
  localparam int DEF_KW         = 8;
  localparam int DEF_NUM_ROUNDS = 32;

  // Sequencer states: buffer the schedule, replay it backwards, pulse done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  // One round-key triple as stored in the buffer: {k0, k1, k2}.
  typedef logic [3*DEF_KW-1:0] key_triple_t;

endpackage

// File: rtl/key_triple_buf.sv
// Register file holding one key triple per round.
// One synchronous write port, one combinational read port.
// Storage is deliberately not reset: every entry is rewritten before it is read.
module key_triple_buf #(
  parameter int DEPTH = 32,
  parameter int W     = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [W-1:0] entry;

      // Capture the incoming triple when this entry is addressed.
      always_ff @(posedge CLK) begin
        if (we && (waddr == AW'(gi))) begin
          entry <= wdata;
        end
      end

      assign mem[gi] = entry;
    end
  endgenerate

  assign rdata = mem[raddr];

endmodule

// File: rtl/decrypt_key_sequencer.sv
// Decryption key sequencer: enables the key schedule, buffers all round-key
// triples in forward order, then replays them last-to-first to the round
// datapath over a valid/ack handshake, reporting busy/done status.
// Optional feature macro: KEY_CACHE_EN (reuse the buffered keys when the key
// has not changed since the last completed pass).
module decrypt_key_sequencer
  import crypt_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int KW         = DEF_KW,
  parameter int IDXW       = $clog2(NUM_ROUNDS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            start,
  input  logic            abort,
  input  logic            key_new,
  output logic            ks_en,
  input  logic            ks_vld,
  input  logic [KW-1:0]   ks_k0,
  input  logic [KW-1:0]   ks_k1,
  input  logic [KW-1:0]   ks_k2,
  output logic            rnd_vld,
  input  logic            rnd_ack,
  output logic [KW-1:0]   rnd_k0,
  output logic [KW-1:0]   rnd_k1,
  output logic [KW-1:0]   rnd_k2,
  output logic [IDXW-1:0] rnd_idx,
  output logic            busy,
  output logic            done
);

  localparam int TW = 3 * KW;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ROUNDS - 1);

  seq_state_t      state_reg, state_next;
  logic [IDXW-1:0] wptr_reg, wptr_next;
  logic [IDXW-1:0] rptr_reg, rptr_next;
  logic            buf_we;
  logic [TW-1:0]   buf_wdata;
  logic [TW-1:0]   buf_rdata;
  logic            cache_hit;
  logic            cache_clr;
  logic            cache_set;

  assign buf_wdata = {ks_k0, ks_k1, ks_k2};

  key_triple_buf #(
    .DEPTH (NUM_ROUNDS),
    .W     (TW),
    .AW    (IDXW)
  ) u_buf (
    .CLK   (CLK),
    .we    (buf_we),
    .waddr (wptr_reg),
    .wdata (buf_wdata),
    .raddr (rptr_reg),
    .rdata (buf_rdata)
  );

`ifdef KEY_CACHE_EN
  logic cache_vld_reg;

  // The buffer still holds the current key's triples after a completed pass.
  assign cache_hit = cache_vld_reg && !key_new;

  // Track whether the buffered triples are reusable by the next start.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cache_vld_reg <= 1'b0;
    end else if (cache_clr) begin
      cache_vld_reg <= 1'b0;
    end else if (cache_set) begin
      cache_vld_reg <= 1'b1;
    end
  end
`else
  // Without the cache every start refills; key_new has no function.
  logic key_new_unused;
  logic cache_flags_unused;
  assign key_new_unused     = key_new;
  assign cache_hit          = 1'b0;
  assign cache_flags_unused = cache_clr ^ cache_set;
`endif

  // State and pointer registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
    end
  end

  // Next-state, pointer updates, buffer write strobe and status outputs.
  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    buf_we     = 1'b0;
    cache_clr  = 1'b0;
    cache_set  = 1'b0;

    ks_en      = (state_reg == FILL);
    rnd_vld    = (state_reg == RUN);
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);

    if (abort) begin
      // Abort wins over everything; an idle block simply stays idle.
      if (state_reg != IDLE) begin
        state_next = IDLE;
        cache_clr  = 1'b1;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            if (cache_hit) begin
              state_next = RUN;
              rptr_next  = LAST_IDX;
            end else begin
              state_next = FILL;
              wptr_next  = '0;
              cache_clr  = 1'b1;
            end
          end
        end
        FILL: begin
          if (ks_vld) begin
            buf_we = 1'b1;
            if (wptr_reg == LAST_IDX) begin
              state_next = RUN;
              rptr_next  = LAST_IDX;
            end else begin
              wptr_next = wptr_reg + 1'b1;
            end
          end
        end
        RUN: begin
          if (rnd_ack) begin
            if (rptr_reg == '0) begin
              state_next = DONE;
            end else begin
              rptr_next = rptr_reg - 1'b1;
            end
          end
        end
        DONE: begin
          state_next = IDLE;
          cache_set  = 1'b1;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Round keys and index are only driven while a triple is being offered.
  always_comb begin
    rnd_k0  = '0;
    rnd_k1  = '0;
    rnd_k2  = '0;
    rnd_idx = '0;
    if (rnd_vld) begin
      rnd_k0  = buf_rdata[3*KW-1:2*KW];
      rnd_k1  = buf_rdata[2*KW-1:KW];
      rnd_k2  = buf_rdata[KW-1:0];
      rnd_idx = rptr_reg;
    end
  end

endmodule

// File: tb/tb_decrypt_key_sequencer.sv
// Directed self-checking bench for decrypt_key_sequencer (NUM_ROUNDS=32, KW=8).
// Honours KEY_CACHE_EN when the bundle is built with it.
module tb_decrypt_key_sequencer;

  localparam int N  = 32;
  localparam int KW = 8;

  logic          CLK;
  logic          RST_N;
  logic          start;
  logic          abort;
  logic          key_new;
  logic          ks_en;
  logic          ks_vld;
  logic [KW-1:0] ks_k0, ks_k1, ks_k2;
  logic          rnd_vld;
  logic          rnd_ack;
  logic [KW-1:0] rnd_k0, rnd_k1, rnd_k2;
  logic [4:0]    rnd_idx;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int salt   = 0;

  decrypt_key_sequencer #(.NUM_ROUNDS(N), .KW(KW)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (start),
    .abort   (abort),
    .key_new (key_new),
    .ks_en   (ks_en),
    .ks_vld  (ks_vld),
    .ks_k0   (ks_k0),
    .ks_k1   (ks_k1),
    .ks_k2   (ks_k2),
    .rnd_vld (rnd_vld),
    .rnd_ack (rnd_ack),
    .rnd_k0  (rnd_k0),
    .rnd_k1  (rnd_k1),
    .rnd_k2  (rnd_k2),
    .rnd_idx (rnd_idx),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hand-defined key pattern: distinct per index for any fixed lane/salt.
  function automatic logic [7:0] kv(input int i, input int lane, input int s);
    int v;
    v = (i * 37 + lane * 101 + s * 59 + 5) % 256;
    return v[7:0];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_keys(input int w);
    ks_k0 = kv(w, 0, salt);
    ks_k1 = kv(w, 1, salt);
    ks_k2 = kv(w, 2, salt);
  endtask

  // Called in FILL cycle 1; supplies nw valid triples (every other cycle if toggle).
  task automatic fill(input int nw, input bit toggle, output int cyc);
    int w;
    bit v;
    w   = 0;
    cyc = 0;
    drive_keys(0);
    while (w < nw && cyc < 200) begin
      chk("fill_ks_en", ks_en, 1);
      v      = toggle ? ((cyc % 2) == 0) : 1'b1;
      ks_vld = v;
      tick();
      if (v) w++;
      drive_keys(w);
      cyc++;
    end
    $display("fill: %0d writes in %0d cycles", w, cyc);
  endtask

  // Called with the DUT in RUN at idx 31; ack every cycle except an optional stall.
  task automatic drain(input int stall_idx, input int start_idx);
    rnd_ack = 1'b1;
    for (int idx = N - 1; idx >= 0; idx--) begin
      chk("run_vld", rnd_vld, 1);
      chk("run_idx", rnd_idx, idx);
      chk("run_k0", rnd_k0, kv(idx, 0, salt));
      chk("run_k1", rnd_k1, kv(idx, 1, salt));
      chk("run_k2", rnd_k2, kv(idx, 2, salt));
      chk("run_no_done", done, 0);
      if (idx == stall_idx) begin
        rnd_ack = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall_idx", rnd_idx, idx);
          chk("stall_k0", rnd_k0, kv(idx, 0, salt));
          chk("stall_k2", rnd_k2, kv(idx, 2, salt));
        end
        rnd_ack = 1'b1;
      end
      start = (idx == start_idx);
      tick();
      start = 1'b0;
    end
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_vld_drop", rnd_vld, 0);
    tick();
    chk("done_clear", done, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("no_second_done", done, 0);
    chk("no_restart", busy, 0);
    rnd_ack = 1'b0;
    $display("drain: pass complete (salt %0d)", salt);
  endtask

  initial begin
    int cyc;
    RST_N   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    key_new = 1'b0;
    ks_vld  = 1'b0;
    rnd_ack = 1'b0;
    ks_k0 = '0; ks_k1 = '0; ks_k2 = '0;

    // Reset state.
    tick();
    tick();
    chk("rst_ks_en", ks_en, 0);
    chk("rst_rnd_vld", rnd_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", rnd_idx, 0);
    chk("rst_k0", rnd_k0, 0);
    RST_N = 1'b1;
    tick();

    // start+abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_ks_en", ks_en, 0);
    $display("idle start+abort: stayed idle");

    // Test 1: contiguous fill, latency, full drain.
    salt = 0;
    start = 1'b1; ks_vld = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_c1", busy, 1);
    fill(N, 1'b0, cyc);
    chk("t1_fill_cycles", cyc, N);
    chk("t1_ks_en_drop", ks_en, 0);
    chk("t1_first_vld", rnd_vld, 1);
    chk("t1_first_idx", rnd_idx, N - 1);
    ks_vld = 1'b0;
    drain(-1, -1);

    // Tests 2/3: gapped fill, extra ks_vld during RUN, stall at idx 20.
    salt = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    fill(N, 1'b1, cyc);
    chk("t2_fill_cycles", cyc, 2 * N - 1);
    chk("t2_run", rnd_vld, 1);
    ks_vld = 1'b1;
    drain(20, -1);
    ks_vld = 1'b0;

    // Test 4a: start pulse during RUN is ignored.
    salt = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    fill(N, 1'b0, cyc);
    drain(-1, 15);

    // Test 4b: abort on the 11th write (wptr 10).
    salt = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    fill(10, 1'b0, cyc);
    chk("t4_pre_abort_en", ks_en, 1);
    abort = 1'b1; ks_vld = 1'b1;
    tick();
    abort = 1'b0; ks_vld = 1'b0;
    chk("t4_abort_ks_en", ks_en, 0);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_done", done, 0);
    chk("t4_abort_vld", rnd_vld, 0);
    tick();
    chk("t4_abort_no_done", done, 0);
    $display("abort during fill: returned to idle");

    // Test 5: asynchronous reset mid-RUN at idx 5, then a fresh refill.
    salt = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    fill(N, 1'b0, cyc);
    rnd_ack = 1'b1;
    while (rnd_idx != 5 && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("t5_at_idx5", rnd_idx, 5);
    RST_N = 1'b0;
    #1;
    chk("t5_rst_vld", rnd_vld, 0);
    chk("t5_rst_idx", rnd_idx, 0);
    chk("t5_rst_k1", rnd_k1, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    rnd_ack = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    $display("async reset mid-run applied");
    salt = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    fill(N, 1'b0, cyc);
    drain(-1, -1);

    // Test 6: second start with key_new=0, then with key_new=1.
    key_new = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef KEY_CACHE_EN
    chk("t6_cache_vld", rnd_vld, 1);
    chk("t6_cache_idx", rnd_idx, N - 1);
    chk("t6_cache_no_ks_en", ks_en, 0);
    drain(-1, -1);
    key_new = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_new = 1'b0;
    chk("t6_newkey_fill", ks_en, 1);
    salt = 6;
    fill(N, 1'b0, cyc);
    drain(-1, -1);
`else
    chk("t6_refill_ks_en", ks_en, 1);
    chk("t6_refill_no_vld", rnd_vld, 0);
    salt = 6;
    fill(N, 1'b0, cyc);
    drain(-1, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
